// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM request arbiter.
package sdram_arb_pkg;

    localparam int unsigned NUM_PORTS       = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned TIMER_W         = 8;

    // Read data returned with an errored (timed-out) acknowledge.
    localparam logic [31:0] ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_rr.sv
// 2-way round-robin grant: a lone requester wins; on contention the port
// that was not served last wins.
//   req  : pending requests, bit N = port N
//   last : port served most recently
//   gnt  : one-hot grant, combinational
module sdram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Serialises two requester ports onto the single sdram_controller command
// interface, round-robin, returning read data and a one-cycle ack (plus err
// on read timeout) to the served port.
//   clk, rst                      : clock, async active-high reset
//   pN_req/we/addr/wdata          : request from port N, held until pN_ack
//   pN_ack/err/rdata              : registered completion to port N
//   ctrl_in_valid/rw/addr/wdata   : registered command to the controller
//   ctrl_busy/out_valid/rdata     : controller handshake and read return
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ctrl_in_valid,
    output logic              ctrl_rw,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    input  logic              ctrl_busy,
    input  logic              ctrl_out_valid,
    input  logic [DATA_W-1:0] ctrl_rdata
);

    arb_state_t state_q, state_d;

    logic                               gnt_q, gnt_d;
    logic                               last_q, last_d;
    logic                               err_q, err_d;
    logic [TIMER_W-1:0]                 timer_q, timer_d;
    logic                               valid_q, valid_d;
    logic                               rw_q, rw_d;
    logic [ADDR_W-1:0]                  addr_q, addr_d;
    logic [DATA_W-1:0]                  wdata_q, wdata_d;
    logic [NUM_PORTS-1:0]               ack_q, ack_d;
    logic [NUM_PORTS-1:0]               perr_q, perr_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0] rr_gnt;

    sdram_arb_rr u_rr (
        .req  ({p1_req, p0_req}),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    // State, command, timer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            timer_q <= '0;
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            perr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            perr_q  <= perr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state; ack/rdata are set on entry to DONE so they show during DONE.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        err_d   = err_q;
        timer_d = timer_q;
        valid_d = 1'b0;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = '0;
        perr_d  = '0;
        rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (|rr_gnt) begin
                    gnt_d   = rr_gnt[1];
                    rw_d    = rr_gnt[1] ? p1_we    : p0_we;
                    addr_d  = rr_gnt[1] ? p1_addr  : p0_addr;
                    wdata_d = rr_gnt[1] ? p1_wdata : p0_wdata;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ctrl_busy) begin
                    valid_d = 1'b1;
                end else if (rw_q) begin
                    ack_d[gnt_q] = 1'b1;
                    state_d      = DONE;
                end else begin
                    timer_d = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (ctrl_out_valid) begin
                    rdata_d[gnt_q] = ctrl_rdata;
                    ack_d[gnt_q]   = 1'b1;
                    state_d        = DONE;
                end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                    err_d          = 1'b1;
                    rdata_d[gnt_q] = DATA_W'(ERR_RDATA);
                    ack_d[gnt_q]   = 1'b1;
                    perr_d[gnt_q]  = 1'b1;
                    state_d        = DONE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            DONE: begin
                last_d  = gnt_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign p0_ack        = ack_q[0];
    assign p1_ack        = ack_q[1];
    assign p0_err        = perr_q[0];
    assign p1_err        = perr_q[1];
    assign p0_rdata      = rdata_q[0];
    assign p1_rdata      = rdata_q[1];
    assign ctrl_in_valid = valid_q;
    assign ctrl_rw       = rw_q;
    assign ctrl_addr     = addr_q;
    assign ctrl_wdata    = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (TIMEOUT=8). Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point.
module tb_sdram_arbiter;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_ack, p0_err, p1_ack, p1_err;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              ctrl_in_valid, ctrl_rw;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic              ctrl_busy, ctrl_out_valid;
    logic [DATA_W-1:0] ctrl_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr),
        .ctrl_wdata(ctrl_wdata), .ctrl_busy(ctrl_busy),
        .ctrl_out_valid(ctrl_out_valid), .ctrl_rdata(ctrl_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All DUT outputs concatenated; every one must be 0 after reset.
    function automatic logic [2*DATA_W+ADDR_W+DATA_W+6-1:0] all_outs();
        return {p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
                ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        ctrl_busy = 0; ctrl_out_valid = 0; ctrl_rdata = '0;
        tick(); tick();
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_p0();
        p0_req = 1; p0_we = 1; p0_addr = 23'h000010; p0_wdata = 32'hA5A5_0001;
        tick();  // cycle 1
        checks++;
        if ({ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata} !== {1'b1, 1'b1, 23'h10, 32'hA5A5_0001}) begin
            failures++;
            $display("FAIL write_cmd: got v=%b rw=%b a=%h d=%h expected v=1 rw=1 a=10 d=a5a50001",
                     ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata);
        end
        checks++;
        if (p0_ack !== 1'b0) begin
            failures++;
            $display("FAIL write_early_ack: got %b expected 0", p0_ack);
        end
        tick();  // cycle 2
        checks++;
        if ({p0_ack, p0_err, p1_ack, ctrl_in_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL write_ack: got p0_ack=%b p0_err=%b p1_ack=%b v=%b expected 1 0 0 0",
                     p0_ack, p0_err, p1_ack, ctrl_in_valid);
        end
        p0_req = 0;
        tick();  // cycle 3
        checks++;
        if ({p0_ack, p1_ack} !== 2'b00) begin
            failures++;
            $display("FAIL write_ack_one_cycle: got %b%b expected 00", p0_ack, p1_ack);
        end
        tick();
    endtask

    task automatic test_read_busy_p1();
        p1_req = 1; p1_we = 0; p1_addr = 23'h000020; p1_wdata = 32'h0;
        ctrl_busy = 1;
        tick();  // cycle 1
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) ctrl_busy = 0;
            checks++;
            if ({ctrl_in_valid, ctrl_rw, ctrl_addr} !== {1'b1, 1'b0, 23'h20}) begin
                failures++;
                $display("FAIL read_cmd_hold c%0d: got v=%b rw=%b a=%h expected v=1 rw=0 a=20",
                         c, ctrl_in_valid, ctrl_rw, ctrl_addr);
            end
            tick();
        end
        // cycle 5: first WAIT_RD cycle
        checks++;
        if (ctrl_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_cmd_drop: got %b expected 0", ctrl_in_valid);
        end
        tick(); tick(); tick();  // cycle 8
        ctrl_out_valid = 1; ctrl_rdata = 32'hDEAD_0020;
        checks++;
        if (p1_ack !== 1'b0) begin
            failures++;
            $display("FAIL read_early_ack: got %b expected 0", p1_ack);
        end
        tick();  // cycle 9
        ctrl_out_valid = 0; ctrl_rdata = '0;
        checks++;
        if ({p1_ack, p1_err, p1_rdata, p0_ack, p0_rdata} !== {1'b1, 1'b0, 32'hDEAD_0020, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL read_ack: got p1_ack=%b err=%b rdata=%h p0_ack=%b p0_rdata=%h expected 1 0 dead0020 0 0",
                     p1_ack, p1_err, p1_rdata, p0_ack, p0_rdata);
        end
        p1_req = 0;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        rst = 1; tick(); rst = 0; tick();
        p0_req = 1; p0_we = 1; p0_addr = 23'h100; p0_wdata = 32'h1;
        p1_req = 1; p1_we = 1; p1_addr = 23'h200; p1_wdata = 32'h2;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            tick();
            if (p0_ack) begin order.push_back(0); when.push_back(c); end
            if (p1_ack) begin order.push_back(1); when.push_back(c); end
        end
        p0_req = 0; p1_req = 0;
        checks++;
        if (order.size() != 6) begin
            failures++;
            $display("FAIL rr_count: got %0d acks expected 6", order.size());
        end
        for (int i = 0; i < order.size() && i < 6; i++) begin
            checks++;
            if (order[i] != i % 2) begin
                failures++;
                $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, order[i], i % 2);
            end
            if (i > 0) begin
                checks++;
                if (when[i] - when[i-1] < 3) begin
                    failures++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles expected >= 3", i, when[i] - when[i-1]);
                end
            end
        end
        tick(); tick();
    endtask

    task automatic test_timeout();
        p0_req = 1; p0_we = 0; p0_addr = 23'h30;
        tick(); tick();  // cycle 2: first WAIT_RD cycle
        for (int c = 2; c <= 10; c++) begin
            checks++;
            if (p0_ack !== 1'b0) begin
                failures++;
                $display("FAIL timeout_early c%0d: got ack=%b expected 0", c, p0_ack);
            end
            tick();
        end
        // cycle 11 = first WAIT_RD + 9
        checks++;
        if ({p0_ack, p0_err, p0_rdata, p1_ack} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h p1_ack=%b expected 1 1 0 0",
                     p0_ack, p0_err, p0_rdata, p1_ack);
        end
        p0_req = 0;
        tick(); tick();
        // follow-up read served normally
        p0_req = 1; p0_addr = 23'h34;
        tick(); tick();  // cycle 2 WAIT_RD
        ctrl_out_valid = 1; ctrl_rdata = 32'h1234_5678;
        tick();  // cycle 3
        ctrl_out_valid = 0; ctrl_rdata = '0;
        checks++;
        if ({p0_ack, p0_err, p0_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            failures++;
            $display("FAIL after_timeout_read: got ack=%b err=%b rdata=%h expected 1 0 12345678",
                     p0_ack, p0_err, p0_rdata);
        end
        p0_req = 0;
        tick(); tick();
    endtask

    task automatic test_stray_out_valid();
        ctrl_out_valid = 1; ctrl_rdata = 32'h0BAD_0BAD;
        tick();
        ctrl_out_valid = 0; ctrl_rdata = '0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({p0_ack, p1_ack, p0_rdata, p1_rdata, ctrl_in_valid} !== '0) begin
                failures++;
                $display("FAIL stray_ov c%0d: got acks=%b%b rd0=%h rd1=%h v=%b expected all 0",
                         c, p0_ack, p1_ack, p0_rdata, p1_rdata, ctrl_in_valid);
            end
            tick();
        end
        // still in IDLE: a write takes the minimum 2-cycle path
        p1_req = 1; p1_we = 1; p1_addr = 23'h44; p1_wdata = 32'h5;
        tick(); tick();
        checks++;
        if ({p1_ack, p0_ack} !== 2'b10) begin
            failures++;
            $display("FAIL stray_then_write: got p1_ack=%b p0_ack=%b expected 1 0", p1_ack, p0_ack);
        end
        p1_req = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_read();
        p1_req = 1; p1_we = 0; p1_addr = 23'h55;
        tick(); tick(); tick();  // in WAIT_RD
        #2 rst = 1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_mid_read: got %h expected 0", all_outs());
        end
        p1_req = 0;
        tick();
        rst = 0;
        p0_req = 1; p0_we = 1; p0_addr = 23'h66; p0_wdata = 32'h6;
        p1_req = 1; p1_we = 1; p1_addr = 23'h77; p1_wdata = 32'h7;
        tick();  // cycle 1
        checks++;
        if ({ctrl_in_valid, ctrl_addr} !== {1'b1, 23'h66}) begin
            failures++;
            $display("FAIL post_reset_grant: got v=%b a=%h expected v=1 a=66", ctrl_in_valid, ctrl_addr);
        end
        tick();  // cycle 2
        checks++;
        if ({p0_ack, p1_ack} !== 2'b10) begin
            failures++;
            $display("FAIL post_reset_ack: got p0=%b p1=%b expected 1 0", p0_ack, p1_ack);
        end
        p0_req = 0; p1_req = 0;
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_write_p0();
        test_read_busy_p1();
        test_round_robin();
        test_timeout();
        test_stray_out_valid();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
